reset_sequencer: RTL and testbench
==================================

# reset_sequencer

Reset-release controller for the register datapath. Asserts reset asynchronously to all downstream register domains, synchronizes the deassertion, holds reset for a programmable interval, then releases the domains one at a time in index order. Each domain acknowledges readiness, or a fixed step delay elapses, before the next domain is released. Sits between the board/system reset and the per-block `reset` inputs of the sync- and async-reset register banks.

## Interface
- `NUM_DOMAINS`, 4: number of sequenced reset domains, 1..8.
- `HOLD_CYCLES`, 8: cycles all domains stay in reset after synchronized release, ≥1.
- `ACK_TIMEOUT`, 16: max cycles to wait for a domain ack, ≥1 (ack mode only).
- `STEP_CYCLES`, 4: fixed spacing between releases, ≥1 (no-ack mode only).
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `sw_reset_req`  in  1  synchronous request to rerun the sequence; honoured only in DONE.
- `domain_ack`  in  NUM_DOMAINS  bit k high means domain k is ready; only the current domain's bit is examined.
- `domain_reset`  out  NUM_DOMAINS  active-high reset to each domain.
- `all_ready`  out  1  all domains released and acknowledged or timed out.
- `busy`  out  1  sequence in progress (SYNC, HOLD or STEP).
- `timeout_err`  out  1  sticky; a domain failed to ack in time.
- `failed_domain`  out  max(1,$clog2(NUM_DOMAINS))  index of the first domain that timed out.

## Operation
- Reset values while `reset`=1, immediately and without a clock: `domain_reset`=all ones, `all_ready`=0, `busy`=1, `timeout_err`=0, `failed_domain`=0, state=SYNC, counters=0.
- Deassertion passes through an internal 2-flop synchronizer preset by `reset`. Assertion is never synchronized.
- States:
  - SYNC: waits for the synchronizer output to go low, then enters HOLD with counter=0.
  - HOLD: counts HOLD_CYCLES edges, then clears `domain_reset[0]`, sets index k=0 and counter=0, and enters STEP.
  - STEP (ack mode): the domain advances on the first edge, among release+1..release+ACK_TIMEOUT, at which `domain_ack[k]`=1. If no ack is seen by edge release+ACK_TIMEOUT, the domain advances at that edge, sets `timeout_err`=1, and loads `failed_domain`=k only if `timeout_err` was 0.
  - STEP (no-ack mode): the domain advances exactly STEP_CYCLES edges after release.
  - Advance: if k<NUM_DOMAINS-1, clear `domain_reset[k+1]` at the same edge, increment k, clear counter. Otherwise go to DONE.
  - DONE: `all_ready`=1, `busy`=0. If `sw_reset_req`=1 at an edge, set all `domain_reset` bits at that edge, set `all_ready`=0 and `busy`=1, clear the counter, and enter HOLD (bypassing SYNC).
- `sw_reset_req` is ignored outside DONE. `domain_ack` bits other than k are ignored. Any `domain_ack` is ignored in SYNC, HOLD and DONE.
- A released domain is never re-asserted except by `reset` or an honoured `sw_reset_req`.
- `timeout_err` and `failed_domain` are cleared only by `reset`. They are not cleared by `sw_reset_req`.

## Timing
- E0 is the first rising edge at which `reset` is sampled low. Synchronizer output falls at E1, and HOLD is entered at E1.
- `domain_reset[0]` falls at E(1+HOLD_CYCLES).
- Ack mode: minimum spacing between releases is 1 cycle. With an ack sampled at the release+1 edge, `all_ready` rises 1 edge after the last release.
- No-ack mode: releases are spaced STEP_CYCLES apart. `all_ready` rises STEP_CYCLES after the last release.
- `reset` asserted mid-sequence or in DONE returns all outputs to their reset values within the same cycle. A subsequent release restarts timing from a new E0.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `RESET_SEQ_ACK_EN` defined: STEP waits on `domain_ack` with the ACK_TIMEOUT watchdog. `timeout_err` and `failed_domain` are live.
- Not defined: `domain_ack` is unused, and STEP uses the fixed STEP_CYCLES spacing. `timeout_err` and `failed_domain` are tied to 0.

## Test plan
(Defaults: NUM_DOMAINS=4, HOLD_CYCLES=8, ACK_TIMEOUT=16, STEP_CYCLES=4.)
- Ack mode, `domain_ack`=4'b1111, release `reset` -> `domain_reset` bits 0..3 fall at E9, E10, E11, E12; `all_ready`=1 and `busy`=0 at E13; `timeout_err`=0.
- Ack mode, `domain_ack[2]` held 0, others 1 -> bit 2 falls at E11; `timeout_err`=1, `failed_domain`=2, and bit 3 falls at E27; `all_ready` at E28.
- No-ack mode -> bits 0..3 fall at E9, E13, E17, E21; `all_ready` at E25; `domain_ack` toggling has no effect.
- Assert `reset` between E10 and E11 -> `domain_reset`=4'b1111, `busy`=1, `all_ready`=0 immediately; after release, the sequence repeats with the same E-relative timing.
- In DONE, pulse `sw_reset_req` at edge S -> `domain_reset`=4'b1111 and `all_ready`=0 after S; bit 0 falls at S+8. Pulsing `sw_reset_req` while `busy`=1 has no effect.
- Ack mode, `domain_ack[3]`=1 while k=1 and `domain_ack[1]`=0 -> no advance until `domain_ack[1]` is sampled 1 or the timeout fires at release+16.

Source files
------------

// File: rtl/reset_sequencer.sv
// reset_sequencer: async-assert / sync-release reset, hold, then in-order
// domain release (ack + watchdog when RESET_SEQ_ACK_EN, else fixed spacing).
// Ports: clk, reset (async, high), sw_reset_req, domain_ack[N] -> domain_reset[N],
//        all_ready, busy, timeout_err (sticky), failed_domain (first timeout).
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int STEP_CYCLES = 4,
  localparam int FW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   sw_reset_req,
  input  logic [NUM_DOMAINS-1:0] domain_ack,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   all_ready,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [FW-1:0]          failed_domain
);

  localparam int MX1 = (HOLD_CYCLES > ACK_TIMEOUT) ? HOLD_CYCLES : ACK_TIMEOUT;
  localparam int MX  = (MX1 > STEP_CYCLES) ? MX1 : STEP_CYCLES;
  localparam int CW  = $clog2(MX + 1);

  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [FW-1:0] K_LAST    = FW'(NUM_DOMAINS - 1);
`ifdef RESET_SEQ_ACK_EN
  localparam logic [CW-1:0] ACK_LAST  = CW'(ACK_TIMEOUT - 1);
`else
  localparam logic [CW-1:0] STEP_LAST = CW'(STEP_CYCLES - 1);
`endif

  typedef enum logic [1:0] {SYNC, HOLD, STEP, DONE} state_t;

  state_t                 state_q, state_n;
  logic [1:0]             sync_q;
  logic [CW-1:0]          cnt_q, cnt_n;
  logic [FW-1:0]          k_q, k_n;
  logic [NUM_DOMAINS-1:0] drst_q, drst_n;
  logic                   rdy_q, busy_q;
  logic                   adv;

`ifdef RESET_SEQ_ACK_EN
  logic          terr_q, terr_n;
  logic [FW-1:0] fdom_q, fdom_n;
`endif

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    k_n     = k_q;
    drst_n  = drst_q;
    adv     = 1'b0;
`ifdef RESET_SEQ_ACK_EN
    terr_n  = terr_q;
    fdom_n  = fdom_q;
`endif
    unique case (state_q)
      SYNC: begin
        // leave on the edge where the output stage falls
        if (sync_q == 2'b10) begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          drst_n[0] = 1'b0;
          k_n       = '0;
          cnt_n     = '0;
          state_n   = STEP;
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      STEP: begin
`ifdef RESET_SEQ_ACK_EN
        if (domain_ack[k_q]) begin
          adv = 1'b1;
        end else if (cnt_q == ACK_LAST) begin
          adv    = 1'b1;
          terr_n = 1'b1;
          if (!terr_q) fdom_n = k_q;
        end
`else
        adv = (cnt_q == STEP_LAST);
`endif
        if (adv) begin
          cnt_n = '0;
          if (k_q == K_LAST) begin
            state_n = DONE;
          end else begin
            k_n         = k_q + 1'b1;
            drst_n[k_n] = 1'b0;
          end
        end else begin
          cnt_n = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (sw_reset_req) begin
          drst_n  = '1;
          cnt_n   = '0;
          state_n = HOLD;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b11;
      state_q <= SYNC;
      cnt_q   <= '0;
      k_q     <= '0;
      drst_q  <= '1;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      sync_q  <= {sync_q[0], 1'b0};
      state_q <= state_n;
      cnt_q   <= cnt_n;
      k_q     <= k_n;
      drst_q  <= drst_n;
      rdy_q   <= (state_n == DONE);
      busy_q  <= (state_n != DONE);
    end
  end

`ifdef RESET_SEQ_ACK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      terr_q <= 1'b0;
      fdom_q <= '0;
    end else begin
      terr_q <= terr_n;
      fdom_q <= fdom_n;
    end
  end

  assign timeout_err   = terr_q;
  assign failed_domain = fdom_q;
`else
  logic unused_ack;
  assign unused_ack    = ^domain_ack;
  assign timeout_err   = 1'b0;
  assign failed_domain = '0;
`endif

  assign domain_reset = drst_q;
  assign all_ready    = rdy_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: edge-time release model + random ack/sw/reset.
// Works in both builds (RESET_SEQ_ACK_EN defined or not).
module tb_reset_sequencer;
  localparam int N    = 4;
  localparam int HOLD = 8;
  localparam int TO   = 16;
  localparam int STEP = 4;
  localparam int FW   = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          sw_reset_req = 1'b0;
  logic [N-1:0]  domain_ack = '0;
  logic [N-1:0]  domain_reset;
  logic          all_ready;
  logic          busy;
  logic          timeout_err;
  logic [FW-1:0] failed_domain;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_DOMAINS(N),
    .HOLD_CYCLES(HOLD),
    .ACK_TIMEOUT(TO),
    .STEP_CYCLES(STEP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sw_reset_req(sw_reset_req),
    .domain_ack(domain_ack),
    .domain_reset(domain_reset),
    .all_ready(all_ready),
    .busy(busy),
    .timeout_err(timeout_err),
    .failed_domain(failed_domain)
  );

  // model: t = edges since reset release (E_t), rel[i] = edge domain i fell
  int t;
  int mode;  // 0 sync, 1 hold, 2 step, 3 done
  int hs;
  int k;
  int rel[N];
  bit m_terr;
  int m_fdom;
  int obs_fall[N];
  int obs_rdy;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", nm, got, exp, t);
    end
  endtask

  task automatic m_reset();
    t = -1;
    mode = 0;
    hs = 0;
    k = 0;
    m_terr = 0;
    m_fdom = 0;
    for (int i = 0; i < N; i++) rel[i] = -1;
  endtask

  task automatic m_edge();
    bit adv;
    adv = 0;
    t++;
    case (mode)
      0: if (t == 1) begin mode = 1; hs = 1; end
      1: if (t == hs + HOLD) begin mode = 2; k = 0; rel[0] = t; end
      2: begin
`ifdef RESET_SEQ_ACK_EN
        if (domain_ack[k]) adv = 1;
        else if (t == rel[k] + TO) begin
          adv = 1;
          if (!m_terr) m_fdom = k;
          m_terr = 1;
        end
`else
        adv = (t == rel[k] + STEP);
`endif
        if (adv) begin
          if (k < N - 1) begin k++; rel[k] = t; end
          else mode = 3;
        end
      end
      default: if (sw_reset_req) begin
        mode = 1;
        hs = t;
        for (int i = 0; i < N; i++) rel[i] = -1;
      end
    endcase
  endtask

  task automatic compare_all();
    logic [N-1:0] e;
    for (int i = 0; i < N; i++) e[i] = (rel[i] < 0);
    chk("domain_reset", 32'(domain_reset), 32'(e));
    chk("busy", 32'(busy), 32'(mode != 3));
    chk("all_ready", 32'(all_ready), 32'(mode == 3));
    chk("timeout_err", 32'(timeout_err), 32'(m_terr));
    chk("failed_domain", 32'(failed_domain), 32'(m_fdom));
  endtask

  task automatic observe();
    for (int i = 0; i < N; i++) begin
      if (domain_reset[i]) obs_fall[i] = -1;
      else if (obs_fall[i] < 0) obs_fall[i] = t;
    end
    if (!all_ready) obs_rdy = -1;
    else if (obs_rdy < 0) obs_rdy = t;
  endtask

  task automatic cycle(input logic r, input logic s, input logic [N-1:0] a);
    @(negedge clk);
    sw_reset_req = s;
    domain_ack = a;
    if (r && !reset) begin
      reset = 1'b1;
      m_reset();
      #1;
      compare_all();
    end else begin
      reset = r;
    end
    @(posedge clk);
    if (!reset) m_edge();
    #1;
    compare_all();
    observe();
  endtask

  task automatic run(input int n, input logic [N-1:0] a, input bit rnd);
    for (int c = 0; c < n; c++)
      cycle(1'b0, 1'b0, rnd ? N'($urandom) : a);
  endtask

  task automatic chk_seq(input string nm, input int f0, input int f1,
                         input int f2, input int f3, input int rdy);
    int f[N];
    f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s_fall%0d", nm, i), 32'(obs_fall[i]), 32'(f[i]));
      chk($sformatf("%s_model%0d", nm, i), 32'(rel[i]), 32'(f[i]));
    end
    chk({nm, "_ready"}, 32'(obs_rdy), 32'(rdy));
  endtask

  task automatic chk_rst_lit(input string nm);
    chk({nm, "_dr"}, 32'(domain_reset), 32'hF);
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_rdy"}, 32'(all_ready), 32'd0);
    chk({nm, "_terr"}, 32'(timeout_err), 32'd0);
  endtask

  initial begin
    int s0;
    logic [N-1:0] mask;
    int d;
    int len;
    for (int i = 0; i < N; i++) obs_fall[i] = -1;
    obs_rdy = -1;
    m_reset();

    cycle(1'b1, 1'b0, '0);
    chk_rst_lit("reset");
    cycle(1'b1, 1'b0, '1);

`ifdef RESET_SEQ_ACK_EN
    run(30, 4'hF, 0);
    chk_seq("ack_all", 9, 10, 11, 12, 13);
    chk("ack_all_terr", 32'(timeout_err), 32'd0);

    cycle(1'b1, 1'b0, '0);
    run(40, 4'b1011, 0);
    chk_seq("dead2", 9, 10, 11, 27, 28);
    chk("dead2_terr", 32'(timeout_err), 32'd1);
    chk("dead2_fdom", 32'(failed_domain), 32'd2);
    cycle(1'b0, 1'b1, 4'hF);
    chk("sw_keeps_terr", 32'(timeout_err), 32'd1);
    chk("sw_keeps_fdom", 32'(failed_domain), 32'd2);

    cycle(1'b1, 1'b0, '0);
    run(40, 4'b1101, 0);
    chk_seq("dead1", 9, 10, 26, 27, 28);
    chk("dead1_fdom", 32'(failed_domain), 32'd1);
`else
    run(30, '0, 1);
    chk_seq("step", 9, 13, 17, 21, 25);
    chk("step_terr", 32'(timeout_err), 32'd0);
`endif

    // reset asserted between E10 and E11, then a clean rerun
    cycle(1'b1, 1'b0, '0);
`ifdef RESET_SEQ_ACK_EN
    run(11, 4'hF, 0);
    cycle(1'b1, 1'b0, 4'hF);
    chk_rst_lit("mid_reset");
    run(30, 4'hF, 0);
    chk_seq("rerun", 9, 10, 11, 12, 13);
`else
    run(11, '0, 1);
    cycle(1'b1, 1'b0, '0);
    chk_rst_lit("mid_reset");
    run(30, '0, 1);
    chk_seq("rerun", 9, 13, 17, 21, 25);
`endif

    // software rerun from DONE; pulses while busy must be ignored
    cycle(1'b0, 1'b1, 4'hF);
    s0 = t;
    chk("sw_dr", 32'(domain_reset), 32'hF);
    chk("sw_rdy", 32'(all_ready), 32'd0);
    for (int c = 0; c < 5; c++)
      cycle(1'b0, 1'($urandom_range(0, 1)), 4'hF);
    run(30, 4'hF, 0);
`ifdef RESET_SEQ_ACK_EN
    chk_seq("sw", s0 + 8, s0 + 9, s0 + 10, s0 + 11, s0 + 12);
`else
    chk_seq("sw", s0 + 8, s0 + 12, s0 + 16, s0 + 20, s0 + 24);
`endif

    // random: each run resets mid-way at an arbitrary point
    for (int it = 0; it < 40; it++) begin
      cycle(1'b1, 1'b0, '0);
      d = $urandom_range(0, N);
      mask = '1;
      if (d < N) mask[d] = 1'b0;
      len = $urandom_range(15, 80);
      for (int c = 0; c < len; c++)
        cycle(1'b0, ($urandom_range(0, 7) == 0),
              N'($urandom) & N'($urandom) & mask);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
